sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller command port between two bus masters: port 0 (CPU) and port 1 (DMA-style peripheral master, e.g. SPI/UART block mover).
- Sits between the hardware memory-switch decode and the sdram controller, on the CPU clock domain.
- Serialises requests, registers the granted command, holds it until the controller accepts it, returns read data and a completion pulse, and enforces priority, anti-starvation and timeout.

---
 rtl/sdram_arbiter_pkg.sv | 20 ++
 rtl/sdram_arbiter_arb_select.sv | 51 +++++
 rtl/sdram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared encodings for the two-port SDRAM command arbiter: FSM states, op codes, port indices.
package sdram_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_CMD    = 3'd2,
      ST_RDWAIT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sdram_arbiter_arb_select.sv
// Two-port winner selection: combinational decision, registered last-grant and starvation count.
// Zero-latency decision; state advances only on cycles where a grant is actually taken.
module sdram_arbiter_arb_select
   import sdram_arbiter_pkg::*;
#(
   parameter int PRIO_MODE  = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic cpu_clk,
   input  logic rst_in,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic win,
   output logic win_vld,
   output logic last_grant
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic [7:0] starve_cnt;
   logic       starved;

   assign starved = (PRIO_MODE == 0) && (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);

   always_comb begin
      win_vld = take & (req0 | req1);
      win     = PORT_CPU;
      if (req1 && !req0) begin
         win = PORT_DMA;
      end else if (req0 && req1) begin
         if (PRIO_MODE == 1) win = ~last_grant;
         else if (starved)   win = PORT_DMA;
      end
   end

   // Count only arbitrations that port 1 actually lost; saturate at the limit.
   always_ff @(posedge cpu_clk) begin
      if (!rst_in) begin
         last_grant <= PORT_CPU;
         starve_cnt <= '0;
      end else if (win_vld) begin
         last_grant <= win;
         if (win == PORT_DMA)
            starve_cnt <= '0;
         else if (req1 && (PRIO_MODE == 0) && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between CPU (port 0) and DMA master (port 1).
// Grant-to-command 1 cycle; command held until mem_cack, done pulses one cycle; timeout aborts with err.
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 23,
   parameter int PRIO_MODE  = 0,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              cpu_clk,
   input  logic              rst_in,
   input  logic              p0_read,
   input  logic              p0_write,
   input  logic              p0_instr,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [15:0]       p0_wdata,
   output logic [31:0]       p0_rdata,
   output logic              p0_done,
   output logic              p0_err,
   input  logic              p1_read,
   input  logic              p1_write,
   input  logic              p1_instr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [15:0]       p1_wdata,
   output logic [31:0]       p1_rdata,
   output logic              p1_done,
   output logic              p1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_instr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_busy,
   input  logic              mem_ready,
   input  logic              mem_cack,
   output logic              grant,
   output logic              active
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_n;
   op_t               lat_op;
   logic [ADDR_W-1:0] lat_addr;
   logic [15:0]       lat_wdata;
   logic              lat_instr;
   logic [7:0]        tcnt;
   logic              err_q;
   logic              take, win, win_vld, capture, abort, t_exp;

   sdram_arbiter_arb_select #(
      .PRIO_MODE  (PRIO_MODE),
      .STARVE_MAX (STARVE_MAX)
   ) u_sel (
      .cpu_clk    (cpu_clk),
      .rst_in     (rst_in),
      .req0       (p0_read | p0_write),
      .req1       (p1_read | p1_write),
      .take       (take),
      .win        (win),
      .win_vld    (win_vld),
      .last_grant (grant)
   );

   assign t_exp = (tcnt == TO_LAST);

   always_comb begin
      state_n = state;
      take    = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state)
         ST_INIT:   if (!mem_busy) state_n = ST_IDLE;
         ST_IDLE: begin
            take = 1'b1;
            if (win_vld) state_n = ST_CMD;
         end
         ST_CMD: begin
            if (mem_cack) begin
               if (lat_op == OP_WR) begin
                  state_n = ST_DONE;
               end else if (mem_ready) begin
                  capture = 1'b1;
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_RDWAIT;
               end
            end else if (t_exp) begin
               abort   = 1'b1;
               state_n = ST_DONE;
            end
         end
         ST_RDWAIT: begin
            if (mem_ready) begin
               capture = 1'b1;
               state_n = ST_DONE;
            end else if (t_exp) begin
               abort   = 1'b1;
               state_n = ST_DONE;
            end
         end
         ST_DONE:   state_n = ST_IDLE;
         default:   state_n = ST_INIT;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (!rst_in) begin
         state     <= ST_INIT;
         lat_op    <= OP_RD;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_instr <= 1'b0;
         tcnt      <= '0;
         err_q     <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         state <= state_n;
         // Timer restarts on every state change so CMD and RDWAIT each get a full budget.
         if (state_n != state)
            tcnt <= '0;
         else if (state == ST_CMD || state == ST_RDWAIT)
            tcnt <= tcnt + 8'd1;
         if (win_vld) begin
            lat_addr  <= win ? p1_addr  : p0_addr;
            lat_wdata <= win ? p1_wdata : p0_wdata;
            lat_instr <= win ? p1_instr : p0_instr;
            lat_op    <= (win ? p1_write : p0_write) ? OP_WR : OP_RD;
         end
         if (state_n == ST_DONE && state != ST_DONE)
            err_q <= abort;
         if (capture) begin
            if (grant == PORT_DMA) p1_rdata <= mem_rdata;
            else                   p0_rdata <= mem_rdata;
         end
      end
   end

   assign mem_read  = (state == ST_CMD) && (lat_op == OP_RD);
   assign mem_write = (state == ST_CMD) && (lat_op == OP_WR);
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_instr = lat_instr;
   assign active    = (state == ST_CMD) || (state == ST_RDWAIT) || (state == ST_DONE);
   assign p0_done   = (state == ST_DONE) && (grant == PORT_CPU);
   assign p1_done   = (state == ST_DONE) && (grant == PORT_DMA);
   assign p0_err    = p0_done && err_q;
   assign p1_err    = p1_done && err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: instance A (fixed priority, short timeout) and instance B (round-robin).
module tb_sdram_arbiter;
   import sdram_arbiter_pkg::*;

   logic cpu_clk = 1'b0;
   logic rst_in  = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int n_chk = 0;
   int n_err = 0;

   // Instance A signals
   logic        a_p0_read = 0, a_p0_write = 0, a_p0_instr = 0;
   logic [22:0] a_p0_addr = '0;
   logic [15:0] a_p0_wdata = '0;
   logic [31:0] a_p0_rdata;
   logic        a_p0_done, a_p0_err;
   logic        a_p1_read = 0, a_p1_write = 0, a_p1_instr = 0;
   logic [22:0] a_p1_addr = '0;
   logic [15:0] a_p1_wdata = '0;
   logic [31:0] a_p1_rdata;
   logic        a_p1_done, a_p1_err;
   logic [22:0] a_mem_addr;
   logic [15:0] a_mem_wdata;
   logic        a_mem_read, a_mem_write, a_mem_instr;
   logic [31:0] a_mem_rdata;
   logic        a_mem_busy = 1'b1, a_mem_ready, a_mem_cack;
   logic        a_grant, a_active;
   logic        a_auto = 0, a_cack_m = 0, a_ready_m = 0;
   logic [31:0] a_rdata_m = '0;

   assign a_mem_cack  = a_auto ? (a_mem_read | a_mem_write) : a_cack_m;
   assign a_mem_ready = a_auto ? a_mem_read : a_ready_m;
   assign a_mem_rdata = a_auto ? (32'hA000_0000 | 32'(a_mem_addr)) : a_rdata_m;

   // Instance B signals: controller always answers immediately
   logic        b_p0_read = 0, b_p1_read = 0, b_zero = 0;
   logic [22:0] b_p0_addr = 23'h1, b_p1_addr = 23'h2;
   logic [15:0] b_wd = '0;
   logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_rdata;
   logic        b_p0_done, b_p0_err, b_p1_done, b_p1_err;
   logic [22:0] b_mem_addr;
   logic [15:0] b_mem_wdata;
   logic        b_mem_read, b_mem_write, b_mem_instr, b_mem_cack, b_mem_ready;
   logic        b_grant, b_active;

   assign b_mem_cack  = b_mem_read | b_mem_write;
   assign b_mem_ready = b_mem_read;
   assign b_mem_rdata = 32'hB000_0000 | 32'(b_mem_addr);

   sdram_arbiter #(.ADDR_W(23), .PRIO_MODE(0), .STARVE_MAX(4), .TIMEOUT(16)) dut_a (
      .cpu_clk(cpu_clk), .rst_in(rst_in),
      .p0_read(a_p0_read), .p0_write(a_p0_write), .p0_instr(a_p0_instr), .p0_addr(a_p0_addr),
      .p0_wdata(a_p0_wdata), .p0_rdata(a_p0_rdata), .p0_done(a_p0_done), .p0_err(a_p0_err),
      .p1_read(a_p1_read), .p1_write(a_p1_write), .p1_instr(a_p1_instr), .p1_addr(a_p1_addr),
      .p1_wdata(a_p1_wdata), .p1_rdata(a_p1_rdata), .p1_done(a_p1_done), .p1_err(a_p1_err),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
      .mem_write(a_mem_write), .mem_instr(a_mem_instr), .mem_rdata(a_mem_rdata),
      .mem_busy(a_mem_busy), .mem_ready(a_mem_ready), .mem_cack(a_mem_cack),
      .grant(a_grant), .active(a_active)
   );

   sdram_arbiter #(.ADDR_W(23), .PRIO_MODE(1), .STARVE_MAX(4), .TIMEOUT(255)) dut_b (
      .cpu_clk(cpu_clk), .rst_in(rst_in),
      .p0_read(b_p0_read), .p0_write(b_zero), .p0_instr(b_zero), .p0_addr(b_p0_addr),
      .p0_wdata(b_wd), .p0_rdata(b_p0_rdata), .p0_done(b_p0_done), .p0_err(b_p0_err),
      .p1_read(b_p1_read), .p1_write(b_zero), .p1_instr(b_zero), .p1_addr(b_p1_addr),
      .p1_wdata(b_wd), .p1_rdata(b_p1_rdata), .p1_done(b_p1_done), .p1_err(b_p1_err),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
      .mem_write(b_mem_write), .mem_instr(b_mem_instr), .mem_rdata(b_mem_rdata),
      .mem_busy(b_zero), .mem_ready(b_mem_ready), .mem_cack(b_mem_cack),
      .grant(b_grant), .active(b_active)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic wait_a_done(output int who);
      bit seen = 0;
      who = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (a_p0_done || a_p1_done) begin
            who  = a_p1_done ? 1 : 0;
            seen = 1;
         end
      end
   endtask

   task automatic wait_b_done(output int who);
      bit seen = 0;
      who = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (b_p0_done || b_p1_done) begin
            who  = b_p1_done ? 1 : 0;
            seen = 1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int who;
      int n;
      int exp_seq [6] = '{0, 0, 0, 0, 1, 0};

      // Test 1: reset, INIT waits for mem_busy, read with separate cack/ready
      a_p0_read = 1; a_p0_addr = 23'h000100; a_p0_instr = 1;
      repeat (3) tick();
      check("rst_mem_read", a_mem_read, 0);
      check("rst_grant", a_grant, 0);
      check("rst_active", a_active, 0);
      check("rst_p0_rdata", a_p0_rdata, 0);
      check("rst_mem_addr", a_mem_addr, 0);
      rst_in = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t1_busy_hold", a_mem_read, 0);
      end
      a_mem_busy = 0;
      tick();
      check("t1_idle_no_cmd", a_mem_read, 0);
      tick();
      check("t1_mem_read", a_mem_read, 1);
      check("t1_mem_addr", a_mem_addr, 32'h100);
      check("t1_mem_instr", a_mem_instr, 1);
      check("t1_active", a_active, 1);
      a_cack_m = 1;
      tick();
      a_cack_m = 0;
      check("t1_cmd_dropped", a_mem_read, 0);
      tick(); tick();
      check("t1_wait_ready", a_p0_done, 0);
      a_ready_m = 1; a_rdata_m = 32'hDEADBEEF;
      tick();
      a_ready_m = 0;
      check("t1_done", a_p0_done, 1);
      check("t1_err", a_p0_err, 0);
      check("t1_rdata", a_p0_rdata, 32'hDEADBEEF);
      check("t1_p1_rdata", a_p1_rdata, 0);
      a_p0_read = 0; a_p0_instr = 0;
      tick();
      check("t1_done_pulse", a_p0_done, 0);
      check("t1_idle_active", a_active, 0);

      // Test 2: write held 4 cycles until cack
      a_p0_write = 1; a_p0_wdata = 16'h1234; a_p0_addr = 23'h000200;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_write_c%0d", i), a_mem_write, 1);
         check($sformatf("t2_addr_c%0d", i), a_mem_addr, 32'h200);
         check($sformatf("t2_wdata_c%0d", i), a_mem_wdata, 32'h1234);
         if (i == 3) a_cack_m = 1;
         tick();
      end
      a_cack_m = 0;
      check("t2_write_drop", a_mem_write, 0);
      check("t2_done", a_p0_done, 1);
      check("t2_no_rdwait", 32'(dut_a.state), 32'(ST_DONE));
      check("t2_rdata_kept", a_p0_rdata, 32'hDEADBEEF);
      a_p0_write = 0;
      tick();

      // Test 3: fixed priority with starvation relief
      a_auto = 1;
      a_p0_read = 1; a_p0_addr = 23'h10;
      a_p1_read = 1; a_p1_addr = 23'h20;
      for (int i = 0; i < 6; i++) begin
         wait_a_done(who);
         check($sformatf("t3_grant%0d", i), who, exp_seq[i]);
         if (i == 3) check("t3_starve_full", 32'(dut_a.u_sel.starve_cnt), 4);
         if (i == 4) begin
            check("t3_starve_clr", 32'(dut_a.u_sel.starve_cnt), 0);
            check("t3_p1_rdata", a_p1_rdata, 32'hA000_0020);
         end
         if (i == 5) check("t3_p0_rdata", a_p0_rdata, 32'hA000_0010);
      end
      a_p0_read = 0; a_p1_read = 0; a_auto = 0;
      tick();

      // Test 5: no cack -> timeout after 16 cycles
      a_p1_read = 1; a_p1_addr = 23'h300;
      tick();
      n = 0;
      while (a_mem_read && n < 40) begin
         n++;
         tick();
      end
      check("t5_cmd_cycles", n, 16);
      check("t5_p1_done", a_p1_done, 1);
      check("t5_p1_err", a_p1_err, 1);
      check("t5_p1_rdata_kept", a_p1_rdata, 32'hA000_0020);
      check("t5_p0_done", a_p0_done, 0);
      a_p1_read = 0;
      tick();
      check("t5_err_clear", a_p1_err, 0);
      a_p1_read = 1; a_p1_addr = 23'h301; a_auto = 1;
      wait_a_done(who);
      check("t5_next_served", who, 1);
      check("t5_next_err", a_p1_err, 0);
      check("t5_next_rdata", a_p1_rdata, 32'hA000_0301);
      a_p1_read = 0; a_auto = 0;
      tick();

      // Test 4: round-robin alternation and no re-grant after drop
      b_p0_read = 1;
      wait_b_done(who);
      check("t4_first", who, 0);
      b_p1_read = 1;
      for (int i = 0; i < 4; i++) begin
         wait_b_done(who);
         check($sformatf("t4_alt%0d", i), who, (i % 2 == 0) ? 1 : 0);
      end
      check("t4_p1_rdata", b_p1_rdata, 32'hB000_0002);
      b_p0_read = 0; b_p1_read = 0;
      tick();
      b_p0_read = 1;
      wait_b_done(who);
      check("t4_single", who, 0);
      tick();
      b_p0_read = 0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b_active) n++;
      end
      check("t4_no_regrant", n, 0);

      // Test 6: reset during RDWAIT
      a_p0_read = 1; a_p0_addr = 23'h400;
      tick();
      a_cack_m = 1;
      tick();
      a_cack_m = 0;
      check("t6_in_rdwait", 32'(dut_a.state), 32'(ST_RDWAIT));
      rst_in = 0; a_mem_busy = 1;
      tick();
      check("t6_rst_read", a_mem_read, 0);
      check("t6_rst_done", a_p0_done, 0);
      check("t6_rst_active", a_active, 0);
      rst_in = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t6_busy_read%0d", i), a_mem_read, 0);
         check($sformatf("t6_busy_done%0d", i), a_p0_done, 0);
      end
      a_mem_busy = 0;
      tick();
      check("t6_idle_read", a_mem_read, 0);
      tick();
      check("t6_regrant", a_mem_read, 1);
      check("t6_addr", a_mem_addr, 32'h400);
      a_cack_m = 1; a_ready_m = 1; a_rdata_m = 32'h1111_2222;
      tick();
      a_cack_m = 0; a_ready_m = 0;
      check("t6_done", a_p0_done, 1);
      check("t6_rdata", a_p0_rdata, 32'h1111_2222);
      a_p0_read = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
